ip_header_gen: RTL and testbench
================================

Name: ip_header_gen

Overview:
Parametrised IPv4 header generator. It sits between the UDP/payload builder and the Ethernet framer. On each start request it latches the per-packet fields (payload length, source and destination IP) and computes the header checksum sequentially. It then streams the 20 header bytes MSB-first over a valid/ready byte interface. The identification field auto-increments per packet.

Parameters:
TTL, 8'h40, time-to-live byte
PROTOCOL, 8'h11, protocol byte (UDP)
TOS, 8'h00, type-of-service byte
DONT_FRAG, 1, sets DF bit; flags/frag word = DONT_FRAG ? 16'h4000 : 16'h0000
ID_INIT, 16'h0000, identification value after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  request header for one packet; sampled only in IDLE
payload_len  in  16  L4 bytes following the header; latched on accepted start
src_ip  in  32  source address; latched on accepted start
dst_ip  in  32  destination address; latched on accepted start
busy  out  1  high from accepted start until the last byte is accepted
err  out  1  one-cycle pulse: start rejected for length overflow
out_data  out  8  header byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts the byte when out_valid && out_ready
out_last  out  1  high with byte 19

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values: busy=0, err=0, out_valid=0, out_last=0, out_data=8'h00, state=IDLE, id=ID_INIT, accumulator=0.
- States: IDLE -> CALC -> SEND -> IDLE.
- IDLE:
  - start=1 and payload_len <= 65515: latch inputs, compute total_len = payload_len + 20, busy<=1, enter CALC.
  - start=1 and payload_len > 65515: err<=1 for exactly one cycle, stay in IDLE, id unchanged.
- CALC: 10 cycles. One 16-bit header word is added per cycle into a 20-bit accumulator (checksum word taken as 0). Word order: {8'h45,TOS}, total_len, id, flags, {TTL,PROTOCOL}, src[31:16], src[15:0], 16'h0000, dst[31:16], dst[15:0].
  - On the last CALC cycle: fold carries twice (acc[15:0]+acc[19:16], repeat), invert, register as csum, enter SEND.
  - Latency: start sampled at edge T; out_valid=1 first at T+11.
- SEND: byte index 0..19 emits 45, TOS, len_hi, len_lo, id_hi, id_lo, flags_hi, flags_lo, TTL, PROTOCOL, csum_hi, csum_lo, src[31:24..7:0], dst[31:24..7:0].
  - Index advances only on out_valid && out_ready.
  - With out_ready=0, out_data and out_last hold stable and out_valid stays 1.
  - After byte 19 is accepted: out_valid<=0, busy<=0, id<=id+1 (wraps FFFF->0000), return to IDLE. The next start is accepted one cycle later, so back-to-back gap is at least 1 cycle.
- start while busy: ignored, no error, latched fields unchanged.
- Input changes on payload_len/src_ip/dst_ip after the accepting edge have no effect on the current header.
- rst mid-CALC or mid-SEND: outputs return to reset values immediately (asynchronously); the partial header is abandoned and id returns to ID_INIT.
- Arithmetic: total_len is 16-bit with no wrap possible, guaranteed by the err check. The accumulator maximum is 10*16'hFFFF < 2^20, so it cannot overflow.

Decomposition:
- Shared include ip_hdr_defs.vh holds:
  - state encodings: IDLE, CALC, SEND
  - VER_IHL=8'h45, HDR_BYTES=20, HDR_WORDS=10, MAX_PAYLOAD=16'd65515
- Sub-module ip_csum_acc: clear, add-word and fold/invert stages for the ones'-complement checksum. Reused later by the UDP checksum path.

Test Plan:
- Nominal: payload_len=19, src=C0A80132, dst=C0A80164, defaults, out_ready=1, start at T -> out_valid rises at T+11. Bytes are 45 00 00 27 00 00 40 00 40 11 B6 DF C0 A8 01 32 C0 A8 01 64. out_last on byte 20; busy falls after it.
- ID increment: repeat the same request -> id bytes 00 01, checksum B6 DE. Force id=FFFF -> next packet id 0000.
- Backpressure: toggle out_ready 1,0,0,1 pseudo-randomly -> identical byte sequence, no drops or duplicates, data stable while stalled.
- Length bound: payload_len=65515 -> total_len FF FF accepted. payload_len=65516 -> single-cycle err, no out_valid, busy stays 0, id unchanged.
- Protocol: start pulses during CALC and SEND are ignored. Assert rst during byte 7 -> out_valid/busy drop at once; a fresh start then yields id=ID_INIT and a correct checksum.
- DONT_FRAG=0, TTL=8'h80: payload_len=19 -> flags 00 00, TTL 80. Checksum matches a bench reference model.

Source files
------------

// File: rtl/ip_header_gen_pkg.sv
// ip_header_gen_pkg: shared states, header constants and checksum fold helper
package ip_header_gen_pkg;
  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;
  localparam logic [7:0]  VER_IHL     = 8'h45;
  localparam int          HDR_BYTES   = 20;
  localparam int          HDR_WORDS   = 10;
  localparam logic [15:0] MAX_PAYLOAD = 16'd65515;
  // Two end-around folds are enough: the first leaves at most a 1-bit carry.
  function automatic logic [15:0] csum_fold(input logic [19:0] v);
    logic [19:0] f;
    f = {4'b0, v[15:0]} + {16'b0, v[19:16]};
    return f[15:0] + {12'b0, f[19:16]};
  endfunction
endpackage

// File: rtl/ip_header_gen_if.sv
// ip_header_gen_if: request fields plus the header byte stream
interface ip_header_gen_if;
  logic        start;
  logic [15:0] payload_len;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic        busy;
  logic        err;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  modport master (output start, payload_len, src_ip, dst_ip, out_ready,
                  input busy, err, out_data, out_valid, out_last);
  modport slave (input start, payload_len, src_ip, dst_ip, out_ready,
                 output busy, err, out_data, out_valid, out_last);
endinterface

// File: rtl/ip_header_gen_csum_acc.sv
// ip_header_gen_csum_acc: ones'-complement checksum accumulator (clear, add, fold/invert)
module ip_header_gen_csum_acc
  import ip_header_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic        fin_i,
  input  logic [15:0] word_i,
  output logic [15:0] csum_o
);
  logic [19:0] acc_q, acc_d;
  logic [15:0] csum_q;
  assign acc_d  = acc_q + {4'b0, word_i};
  assign csum_o = csum_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= acc_d;
      if (fin_i) csum_q <= ~csum_fold(acc_d);
    end
endmodule

// File: rtl/ip_header_gen.sv
// ip_header_gen: IPv4 header generator, sequential checksum then 20-byte MSB-first stream
module ip_header_gen
  import ip_header_gen_pkg::*;
#(
  parameter logic [7:0]  TTL       = 8'h40,
  parameter logic [7:0]  PROTOCOL  = 8'h11,
  parameter logic [7:0]  TOS       = 8'h00,
  parameter bit          DONT_FRAG = 1'b1,
  parameter logic [15:0] ID_INIT   = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  ip_header_gen_if.slave bus
);
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] id_q, len_q, flags, csum, word;
  logic [31:0] src_q, dst_q;
  logic        busy_q, err_q, valid_q, last_q, accept, fin;
  logic [7:0]  data_q;
  logic [7:0]  hdr [HDR_BYTES];
  assign flags  = DONT_FRAG ? 16'h4000 : 16'h0000;
  assign accept = state_q == IDLE && bus.start && bus.payload_len <= MAX_PAYLOAD;
  assign fin    = state_q == CALC && cnt_q == 4'(HDR_WORDS - 1);
  assign idx_d  = idx_q + 5'd1;
  // Checksum word slot (word 5) contributes zero while summing.
  assign word   = cnt_q == 4'd5 ? 16'h0000 : {hdr[{cnt_q, 1'b0}], hdr[{cnt_q, 1'b1}]};
  always_comb
    hdr = '{VER_IHL, TOS, len_q[15:8], len_q[7:0], id_q[15:8], id_q[7:0],
            flags[15:8], flags[7:0], TTL, PROTOCOL, csum[15:8], csum[7:0],
            src_q[31:24], src_q[23:16], src_q[15:8], src_q[7:0],
            dst_q[31:24], dst_q[23:16], dst_q[15:8], dst_q[7:0]};
  ip_header_gen_csum_acc u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .add_i  (state_q == CALC),
    .fin_i  (fin),
    .word_i (word),
    .csum_o (csum)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      id_q    <= ID_INIT;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      err_q <= state_q == IDLE && bus.start && bus.payload_len > MAX_PAYLOAD;
      case (state_q)
        IDLE: if (accept) begin
          len_q   <= bus.payload_len + 16'd20;
          src_q   <= bus.src_ip;
          dst_q   <= bus.dst_ip;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          cnt_q <= cnt_q + 4'd1;
          if (fin) begin
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: if (!valid_q) begin
          valid_q <= 1'b1;
          data_q  <= hdr[0];
        end else if (bus.out_ready) begin
          if (last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= id_q + 16'd1;
            state_q <= IDLE;
          end else begin
            idx_q  <= idx_d;
            data_q <= hdr[idx_d];
            last_q <= idx_d == 5'(HDR_BYTES - 1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_ip_header_gen.sv
// tb_ip_header_gen: two DUT variants (defaults; DF=0/TTL=80/ID_INIT=FFFF) checked against a byte-level header model
module tb_ip_header_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_v;
  logic [15:0] len_v;
  logic [31:0] src_v, dst_v;
  logic        ready;
  logic        sel;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_id [2];
  logic [7:0]  got [20];

  ip_header_gen_if i0 ();
  ip_header_gen_if i1 ();

  assign i0.start = start_v[0];
  assign i1.start = start_v[1];
  assign i0.payload_len = len_v;
  assign i1.payload_len = len_v;
  assign i0.src_ip = src_v;
  assign i1.src_ip = src_v;
  assign i0.dst_ip = dst_v;
  assign i1.dst_ip = dst_v;
  assign i0.out_ready = ready;
  assign i1.out_ready = ready;

  ip_header_gen d0 (.clk(clk), .rst(rst), .bus(i0));
  ip_header_gen #(.TTL(8'h80), .DONT_FRAG(1'b0), .ID_INIT(16'hFFFF)) d1 (.clk(clk), .rst(rst), .bus(i1));

  logic [7:0] o_data;
  logic       o_valid, o_last, o_busy, o_err;
  assign o_data  = sel ? i1.out_data  : i0.out_data;
  assign o_valid = sel ? i1.out_valid : i0.out_valid;
  assign o_last  = sel ? i1.out_last  : i0.out_last;
  assign o_busy  = sel ? i1.busy      : i0.busy;
  assign o_err   = sel ? i1.err       : i0.err;

  always #5 clk = ~clk;

  function automatic logic [159:0] exp_hdr(input logic [15:0] len, input logic [31:0] src,
                                            input logic [31:0] dst, input logic [15:0] id,
                                            input logic [7:0] ttl, input bit df);
    logic [159:0] h;
    logic [31:0]  s;
    h = {8'h45, 8'h00, len + 16'd20, id, df ? 16'h4000 : 16'h0000, ttl, 8'h11, 16'h0000, src, dst};
    s = 0;
    for (int i = 0; i < 10; i++) s = s + {16'h0, h[159-16*i -: 16]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    h[79:64] = ~s[15:0];
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_pkt(input bit s, input logic [15:0] len, input logic [31:0] src,
                         input logic [31:0] dst, input bit stall, input bit poke, input int abort_at);
    logic [159:0] e;
    int n, k, cyc;
    e = exp_hdr(len, src, dst, exp_id[s], s ? 8'h80 : 8'h40, !s);
    sel = s;
    @(negedge clk);
    start_v[s] = 1'b1;
    len_v = len;
    src_v = src;
    dst_v = dst;
    @(posedge clk); #1;
    start_v = '0;
    len_v = 16'($urandom);
    src_v = $urandom;
    dst_v = $urandom;
    chk("busy_on_accept", 32'(o_busy), 32'd1);
    n = 0;
    while (!o_valid && n < 40) begin
      start_v[s] = poke && n == 3;
      @(posedge clk); #1;
      n++;
    end
    start_v = '0;
    chk("first_valid_latency", n, 11);
    k = 0;
    cyc = 0;
    while (k < 20 && cyc < 400) begin
      chk($sformatf("byte%0d", k), 32'(o_data), 32'(e[159-8*k -: 8]));
      chk($sformatf("last%0d", k), 32'(o_last), 32'(k == 19));
      chk($sformatf("valid%0d", k), 32'(o_valid), 32'd1);
      chk($sformatf("err_quiet%0d", k), 32'(o_err), 32'd0);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_data", 32'(o_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_id[0] = 16'h0000;
        exp_id[1] = 16'hFFFF;
        return;
      end
      got[k] = o_data;
      ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start_v[s] = poke && k == 5;
      @(posedge clk); #1;
      cyc++;
      if (ready) k++;
    end
    start_v = '0;
    ready = 1'b1;
    chk("all_bytes_within_budget", k, 20);
    chk("valid_after_last", 32'(o_valid), 32'd0);
    chk("busy_after_last", 32'(o_busy), 32'd0);
    exp_id[s] = exp_id[s] + 16'd1;
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0;
    len_v = '0;
    src_v = '0;
    dst_v = '0;
    ready = 1'b1;
    sel = 1'b0;
    exp_id[0] = 16'h0000;
    exp_id[1] = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(i0.out_valid), 32'd0);
    chk("rst_busy", 32'(i0.busy), 32'd0);
    chk("rst_err", 32'(i0.err), 32'd0);
    chk("rst_last", 32'(i0.out_last), 32'd0);
    chk("rst_data", 32'(i0.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_pkt(1'b0, 16'd19, 32'hC0A80132, 32'hC0A80164, 1'b0, 1'b0, -1);
    chk("nom_len_lo", 32'(got[3]), 32'h27);
    chk("nom_id_lo", 32'(got[5]), 32'h00);
    chk("nom_csum_hi", 32'(got[10]), 32'hB6);
    chk("nom_csum_lo", 32'(got[11]), 32'hDF);

    run_pkt(1'b0, 16'd19, 32'hC0A80132, 32'hC0A80164, 1'b0, 1'b0, -1);
    chk("id1_lo", 32'(got[5]), 32'h01);
    chk("id1_csum_lo", 32'(got[11]), 32'hDE);

    run_pkt(1'b0, 16'd19, 32'hC0A80132, 32'hC0A80164, 1'b1, 1'b0, -1);

    run_pkt(1'b0, 16'd65515, $urandom, $urandom, 1'b0, 1'b0, -1);
    chk("maxlen_hi", 32'(got[2]), 32'hFF);
    chk("maxlen_lo", 32'(got[3]), 32'hFF);

    sel = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    len_v = 16'd65516;
    @(posedge clk); #1;
    start_v = '0;
    chk("ovf_err_pulse", 32'(o_err), 32'd1);
    chk("ovf_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk("ovf_err_cleared", 32'(o_err), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("ovf_no_valid", 32'(o_valid), 32'd0);
    chk("ovf_still_idle", 32'(o_busy), 32'd0);

    run_pkt(1'b0, 16'($urandom_range(0, 65515)), $urandom, $urandom, 1'b1, 1'b1, -1);

    run_pkt(1'b0, 16'd19, 32'hC0A80132, 32'hC0A80164, 1'b0, 1'b0, 7);
    run_pkt(1'b0, 16'd19, 32'hC0A80132, 32'hC0A80164, 1'b0, 1'b0, -1);
    chk("post_rst_id_lo", 32'(got[5]), 32'h00);
    chk("post_rst_csum_hi", 32'(got[10]), 32'hB6);
    chk("post_rst_csum_lo", 32'(got[11]), 32'hDF);

    run_pkt(1'b1, 16'd19, 32'hC0A80132, 32'hC0A80164, 1'b0, 1'b0, -1);
    chk("v1_id_hi", 32'(got[4]), 32'hFF);
    chk("v1_flags_hi", 32'(got[6]), 32'h00);
    chk("v1_ttl", 32'(got[8]), 32'h80);
    run_pkt(1'b1, 16'd19, 32'hC0A80132, 32'hC0A80164, 1'b1, 1'b0, -1);
    chk("v1_wrap_id_hi", 32'(got[4]), 32'h00);
    chk("v1_wrap_id_lo", 32'(got[5]), 32'h00);

    for (int p = 0; p < 6; p++)
      run_pkt(1'(p % 2), 16'($urandom_range(0, 65515)), $urandom, $urandom, 1'b1, p == 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
